wrapped_core_wir_wby: RTL and testbench

IEEE 1500-style test wrapper around a small functional core, clocked by WRCK. It contains:
- a 3-bit Wrapper Instruction Register (WIR);
- a 1-bit Wrapper Bypass register (WBY);
- a 22-bit Wrapper Boundary Register (WBR) on the core's ADDR/DIN inputs and Dout output;
- a 4-bit parallel port pass-through.

The serial scan path runs WSI -> selected register -> WSO. It is used for core-to-core interconnect test (WS_EXTEST) and core test (WS_INTEST).

---
 rtl/wrapped_core_wir_wby_if.sv | 29 ++
 rtl/wrapped_core_wir_wby.sv | 116 +++++++++++
 tb/tb_wrapped_core_wir_wby.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wrapped_core_wir_wby_if.sv
// Wrapper serial/parallel port and functional pin bundle for wrapped_core_wir_wby.
`default_nettype none

interface wrapped_core_wir_wby_if;
    logic       SelectWIR;
    logic       ShiftWR;
    logic       CaptureWR;
    logic       UpdateWR;
    logic       WSI;
    logic       WSO;
    logic       WPSE;
    logic [3:0] WPSI;
    logic [3:0] WPSO;
    logic [5:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] Dout;

    modport master (
        output SelectWIR, ShiftWR, CaptureWR, UpdateWR, WSI, WPSE, WPSI, ADDR, DIN,
        input  WSO, WPSO, Dout
    );

    modport slave (
        input  SelectWIR, ShiftWR, CaptureWR, UpdateWR, WSI, WPSE, WPSI, ADDR, DIN,
        output WSO, WPSO, Dout
    );
endinterface

`default_nettype wire

// File: rtl/wrapped_core_wir_wby.sv
// IEEE 1500-style wrapper (WIR, WBY, 22-bit WBR, parallel port) around an adder core.
// Revision: 1.0
`default_nettype none

module wrapped_core_wir_wby #(
    parameter int WIR_LEN = 3,
    parameter int WBR_LEN = 22
) (
    input  wire logic             WRCK,
    input  wire logic             RESET,
    wrapped_core_wir_wby_if.slave wp
);

    localparam logic [WIR_LEN-1:0] WS_INTEST = WIR_LEN'(1);
    localparam logic [WIR_LEN-1:0] WS_EXTEST = WIR_LEN'(2);

    logic [WIR_LEN-1:0] wir_shift;
    logic [WIR_LEN-1:0] wir_active;
    logic               wby;
    logic [WBR_LEN-1:0] wbr_shift;
    logic [WBR_LEN-1:0] wbr_upd;
    logic [7:0]         core_q;
    logic [3:0]         wpso_q;

    logic               is_intest;
    logic               is_bypass;
    logic               do_shift;
    logic               do_capture;
    logic               wir_sel;
    logic               wby_sel;
    logic               wbr_sel;
    logic [5:0]         core_addr;
    logic [7:0]         core_din;

    // Unknown codes fall back to bypass so the core stays functional.
    assign is_intest = (wir_active == WS_INTEST);
    assign is_bypass = (wir_active != WS_INTEST) && (wir_active != WS_EXTEST);

    // Shift and capture together is the apply/hold state.
    assign do_shift   = wp.ShiftWR & ~wp.CaptureWR;
    assign do_capture = wp.CaptureWR & ~wp.ShiftWR;

    assign wir_sel = wp.SelectWIR;
    assign wby_sel = ~wp.SelectWIR & is_bypass;
    assign wbr_sel = ~wp.SelectWIR & ~is_bypass;

    always_comb begin
        core_addr = wp.ADDR;
        core_din  = wp.DIN;
        if (is_intest) begin
            core_addr = wbr_upd[WBR_LEN-1 -: 6];
            core_din  = wbr_upd[15:8];
        end
    end

    assign wp.Dout = is_bypass ? core_q : wbr_upd[7:0];
    assign wp.WSO  = wir_sel ? wir_shift[0] : (wby_sel ? wby : wbr_shift[0]);
    assign wp.WPSO = wpso_q;

    always_ff @(posedge WRCK) begin
        if (RESET) begin
            wir_shift  <= '0;
            wir_active <= '0;
        end else if (wir_sel) begin
            if (do_shift) begin
                wir_shift <= {wp.WSI, wir_shift[WIR_LEN-1:1]};
            end else if (do_capture) begin
                wir_shift <= wir_active;
            end
            if (wp.UpdateWR) begin
                wir_active <= wir_shift;
            end
        end
    end

    always_ff @(posedge WRCK) begin
        if (RESET) begin
            wby <= 1'b0;
        end else if (wby_sel) begin
            if (do_shift) begin
                wby <= wp.WSI;
            end else if (do_capture) begin
                wby <= 1'b0;
            end
        end
    end

    always_ff @(posedge WRCK) begin
        if (RESET) begin
            wbr_shift <= '0;
            wbr_upd   <= '0;
        end else if (wbr_sel) begin
            if (do_shift) begin
                wbr_shift <= {wp.WSI, wbr_shift[WBR_LEN-1:1]};
            end else if (do_capture) begin
                wbr_shift <= {wp.ADDR, wp.DIN, core_q};
            end
            if (wp.UpdateWR) begin
                wbr_upd <= wbr_shift;
            end
        end
    end

    always_ff @(posedge WRCK) begin
        if (RESET) begin
            core_q <= '0;
            wpso_q <= '0;
        end else begin
            core_q <= core_din + {2'b00, core_addr};
            wpso_q <= wp.WPSE ? wp.WPSI : 4'b0000;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wrapped_core_wir_wby.sv
// Directed self-checking bench for wrapped_core_wir_wby.
`default_nettype none

module tb_wrapped_core_wir_wby;

    logic WRCK;
    logic RESET;
    int   checks;
    int   errors;

    wrapped_core_wir_wby_if wif ();

    wrapped_core_wir_wby dut (
        .WRCK  (WRCK),
        .RESET (RESET),
        .wp    (wif.slave)
    );

    initial WRCK = 1'b0;
    always #5 WRCK = ~WRCK;

    task automatic step();
        @(posedge WRCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [11:0] wir_stream;
        logic [21:0] cap_exp;
        logic [21:0] pat;
        logic [21:0] got;
        checks = 0;
        errors = 0;
        wir_stream = 12'b010010010010;
        RESET = 1'b1;
        wif.SelectWIR = 1'b0;
        wif.ShiftWR   = 1'b0;
        wif.CaptureWR = 1'b0;
        wif.UpdateWR  = 1'b0;
        wif.WSI       = 1'b0;
        wif.WPSE      = 1'b0;
        wif.WPSI      = 4'b0000;
        wif.ADDR      = 6'd0;
        wif.DIN       = 8'd0;

        repeat (3) step();
        chk("reset_wso", 32'(wif.WSO), 32'd0);
        chk("reset_wpso", 32'(wif.WPSO), 32'd0);
        chk("reset_wir", 32'(dut.wir_active), 32'd0);
        chk("reset_dout", 32'(wif.Dout), 32'd0);

        // Bypass register: shift a 1 through WBY
        RESET = 1'b0;
        wif.ShiftWR = 1'b1;
        wif.WSI = 1'b1;
        step();
        chk("wby_shift", 32'(wif.WSO), 32'd1);
        wif.ShiftWR = 1'b0;
        wif.WSI = 1'b0;

        // Load WS_EXTEST through a 12-bit stream
        wif.SelectWIR = 1'b1;
        wif.ShiftWR = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wif.WSI = wir_stream[11-k];
            step();
            chk("wir_shift_wso", 32'(wif.WSO), (k >= 2) ? 32'(wir_stream[11-(k-2)]) : 32'd0);
        end
        wif.ShiftWR = 1'b0;
        wif.WSI = 1'b0;
        chk("wir_pre_update_wso", 32'(wif.WSO), 32'd0);
        chk("wir_pre_update_active", 32'(dut.wir_active), 32'd0);
        wif.UpdateWR = 1'b1;
        step();
        wif.UpdateWR = 1'b0;
        chk("wir_extest_active", 32'(dut.wir_active), 32'd2);
        chk("wir_post_update_wso", 32'(wif.WSO), 32'd0);

        // EXTEST capture, then shift out while shifting in 0xA5 to bits 7:0
        wif.SelectWIR = 1'b0;
        wif.ADDR = 6'b100001;
        wif.DIN = 8'b10000001;
        wif.CaptureWR = 1'b1;
        step();
        wif.CaptureWR = 1'b0;
        cap_exp = {6'b100001, 8'b10000001, 8'h00};
        pat = 22'h0000A5;
        wif.ShiftWR = 1'b1;
        got = '0;
        for (int i = 0; i < 22; i++) begin
            got[i] = wif.WSO;
            wif.WSI = pat[i];
            step();
        end
        wif.ShiftWR = 1'b0;
        chk("extest_capture", 32'(got), 32'(cap_exp));
        chk("extest_dout_pre_update", 32'(wif.Dout), 32'd0);
        wif.UpdateWR = 1'b1;
        step();
        wif.UpdateWR = 1'b0;
        chk("extest_dout_a5", 32'(wif.Dout), 32'hA5);
        chk("extest_core_q", 32'(dut.core_q), 32'hA2);

        // Apply/hold: shift and capture together leave the WBR untouched
        wif.ShiftWR = 1'b1;
        wif.CaptureWR = 1'b1;
        wif.WSI = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_wso", 32'(wif.WSO), 32'd1);
        end
        chk("hold_wbr", 32'(dut.wbr_shift), 32'(pat));
        wif.ShiftWR = 1'b0;
        wif.CaptureWR = 1'b0;
        wif.WSI = 1'b0;

        // Back to WS_BYPASS: core result wraps at 256
        wif.SelectWIR = 1'b1;
        wif.ShiftWR = 1'b1;
        repeat (3) step();
        wif.ShiftWR = 1'b0;
        wif.UpdateWR = 1'b1;
        step();
        wif.UpdateWR = 1'b0;
        chk("wir_bypass_active", 32'(dut.wir_active), 32'd0);
        wif.SelectWIR = 1'b0;
        wif.ADDR = 6'd3;
        wif.DIN = 8'hFE;
        step();
        chk("bypass_wrap", 32'(wif.Dout), 32'h01);

        // WS_INTEST: WBR update stage drives the core
        wif.SelectWIR = 1'b1;
        wif.ShiftWR = 1'b1;
        wif.WSI = 1'b1;
        step();
        wif.WSI = 1'b0;
        repeat (2) step();
        wif.ShiftWR = 1'b0;
        wif.UpdateWR = 1'b1;
        step();
        wif.UpdateWR = 1'b0;
        chk("wir_intest_active", 32'(dut.wir_active), 32'd1);
        wif.SelectWIR = 1'b0;
        chk("intest_dout_hold", 32'(wif.Dout), 32'hA5);
        pat = {6'd5, 8'h10, 8'h00};
        wif.ShiftWR = 1'b1;
        got = '0;
        for (int i = 0; i < 22; i++) begin
            got[i] = wif.WSO;
            wif.WSI = pat[i];
            step();
        end
        wif.ShiftWR = 1'b0;
        chk("intest_shift_out", 32'(got), 32'h0000A5);
        wif.UpdateWR = 1'b1;
        step();
        wif.UpdateWR = 1'b0;
        step();
        chk("intest_dout", 32'(wif.Dout), 32'h00);
        wif.CaptureWR = 1'b1;
        step();
        wif.CaptureWR = 1'b0;
        wif.ShiftWR = 1'b1;
        got = '0;
        for (int i = 0; i < 22; i++) begin
            got[i] = wif.WSO;
            step();
        end
        wif.ShiftWR = 1'b0;
        chk("intest_capture", 32'(got), 32'({6'd3, 8'hFE, 8'h15}));

        // Parallel port, then reset in the middle of a WIR shift
        wif.WPSE = 1'b1;
        wif.WPSI = 4'b1010;
        wif.SelectWIR = 1'b1;
        wif.ShiftWR = 1'b1;
        wif.WSI = 1'b1;
        step();
        chk("wpso_pass", 32'(wif.WPSO), 32'hA);
        step();
        chk("wir_mid_shift_wso", 32'(wif.WSO), 32'd0);
        RESET = 1'b1;
        step();
        chk("midreset_wir", 32'(dut.wir_active), 32'd0);
        chk("midreset_wpso", 32'(wif.WPSO), 32'd0);
        chk("midreset_wso", 32'(wif.WSO), 32'd0);
        chk("midreset_dout", 32'(wif.Dout), 32'd0);
        RESET = 1'b0;
        wif.ShiftWR = 1'b0;
        wif.WPSE = 1'b0;
        step();
        chk("wpso_disabled", 32'(wif.WPSO), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
